// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types and the L1 icache controller state encoding.
// Latency: none (types only).
// Backpressure: none (types only).
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    // Default L1 line bus; the cache port width follows its LINE_BYTES parameter.
    typedef logic [127:0] pmem_L1_bus;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FILL  = 2'd2
    } icache_state_t;

endpackage

// File: rtl/icache_plru.sv
// Per-set tree-PLRU state for the set-associative icache; reports the victim way of one set.
// Latency: victim is combinational from the addressed set; touches and clears land at the clock edge.
// Backpressure: none; a touch or clear is always accepted.
module icache_plru #(
    parameter int NUM_WAYS = 2,
    parameter int NUM_SETS = 8
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           clear,
    input  logic [$clog2(NUM_SETS)-1:0]                    set_idx,
    input  logic [((NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1)-1:0] touch_way,
    input  logic                                           touch_en,
    output logic [((NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1)-1:0] victim_way
);

    localparam int LVL = $clog2(NUM_WAYS);
    localparam int NB  = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;
    localparam int WW  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    // Heap-ordered tree: node n (root n=1) lives in bit n-1.
    // A node bit of 0 steers the victim search left, 1 steers it right.
    logic [NB-1:0] tree_q [NUM_SETS];

    // Point every node on the way's path away from it, making that way MRU.
    function automatic logic [NB-1:0] plru_touch(input logic [NB-1:0] cur, input logic [WW-1:0] way);
        logic [NB-1:0] nxt;
        int node;
        int dir;
        nxt  = cur;
        node = 1;
        for (int l = 0; l < LVL; l++) begin
            dir           = int'(way[LVL-1-l]);
            nxt[node-1]   = (dir == 0);
            node          = 2 * node + dir;
        end
        return nxt;
    endfunction

    // Follow the node bits from the root down to a leaf.
    function automatic logic [WW-1:0] plru_victim(input logic [NB-1:0] t);
        int node;
        node = 1;
        for (int l = 0; l < LVL; l++) begin
            node = 2 * node + int'(t[node-1]);
        end
        return WW'(node - NUM_WAYS);
    endfunction

    assign victim_way = plru_victim(tree_q[set_idx]);

    // Clear wipes every set; a touch in the same cycle is applied on top of the cleared tree.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) tree_q[s] <= '0;
        end else begin
            if (clear) begin
                for (int s = 0; s < NUM_SETS; s++) tree_q[s] <= '0;
            end
            if (touch_en) begin
                tree_q[set_idx] <= plru_touch(clear ? '0 : tree_q[set_idx], touch_way);
            end
        end
    end

endmodule

// File: rtl/l1_icache_assoc.sv
// Read-only set-associative L1 instruction cache with tree-PLRU replacement and bulk flush.
// Latency: hits respond in the request cycle; a miss responds pmem latency + 2 cycles after the request.
// Backpressure: blocking; one line fill outstanding, mem_read is held by the CPU until mem_resp.
import lc3b_types::*;

module l1_icache_assoc #(
    parameter int NUM_WAYS   = 2,
    parameter int NUM_SETS   = 8,
    parameter int LINE_BYTES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_read,
    input  logic [15:0]             mem_address,
    output logic                    mem_resp,
    output logic [15:0]             mem_rdata,
    input  logic                    flush,
    output logic [15:0]             pmem_address,
    output logic                    pmem_read,
    input  logic [LINE_BYTES*8-1:0] pmem_rdata,
    input  logic                    pmem_resp
);

    localparam int OFF  = $clog2(LINE_BYTES);
    localparam int IDX  = $clog2(NUM_SETS);
    localparam int TAGW = 16 - OFF - IDX;
    localparam int WSW  = OFF - 1;
    localparam int WW   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int LW   = LINE_BYTES * 8;

    icache_state_t       state;
    logic [TAGW-1:0]     tag_q   [NUM_SETS][NUM_WAYS];
    logic [LW-1:0]       data_q  [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [WW-1:0]       victim_q;
    logic [LW-1:0]       fill_buf;

    logic [TAGW-1:0] req_tag;
    logic [IDX-1:0]  req_idx;
    logic [WSW-1:0]  req_word;
    logic [TAGW-1:0] fill_tag;
    logic [IDX-1:0]  fill_idx;

    logic            hit_any;
    logic [WW-1:0]   hit_way;
    logic            inv_any;
    logic [WW-1:0]   inv_way;
    logic [WW-1:0]   plru_way;
    logic [WW-1:0]   victim;
    logic [IDX-1:0]  plru_set;
    logic [WW-1:0]   touch_way;
    logic            touch_en;

    assign req_tag  = mem_address[15 -: TAGW];
    assign req_idx  = mem_address[OFF +: IDX];
    assign req_word = mem_address[1 +: WSW];
    // The latched line address doubles as the fill target.
    assign fill_tag = pmem_address[15 -: TAGW];
    assign fill_idx = pmem_address[OFF +: IDX];

    // Tag compare across all ways of the requested set.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit_any = 1'b1;
                hit_way = WW'(w);
            end
        end
    end

    // Victim: lowest-index invalid way first, otherwise the PLRU choice.
    always_comb begin
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) begin
                inv_any = 1'b1;
                inv_way = WW'(w);
            end
        end
        victim = inv_any ? inv_way : plru_way;
    end

    assign mem_resp  = (state == IDLE) && mem_read && hit_any;
    assign mem_rdata = data_q[req_idx][hit_way][{req_word, 4'b0000} +: 16];

    // A flush beats a same-cycle hit for PLRU purposes; the fill always marks its way MRU.
    assign plru_set  = (state == FILL) ? fill_idx : req_idx;
    assign touch_way = (state == FILL) ? victim_q : hit_way;
    assign touch_en  = (state == FILL) || ((state == IDLE) && mem_read && hit_any && !flush);

    icache_plru #(
        .NUM_WAYS (NUM_WAYS),
        .NUM_SETS (NUM_SETS)
    ) u_plru (
        .clk        (clk),
        .rst        (rst),
        .clear      (flush),
        .set_idx    (plru_set),
        .touch_way  (touch_way),
        .touch_en   (touch_en),
        .victim_way (plru_way)
    );

    // Miss FSM: latch line address and victim, hold the fill request, then install the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pmem_read    <= 1'b0;
            pmem_address <= '0;
            victim_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_read && !hit_any) begin
                        pmem_address <= {mem_address[15:OFF], {OFF{1'b0}}};
                        victim_q     <= victim;
                        pmem_read    <= 1'b1;
                        state        <= FETCH;
                    end
                end
                FETCH: begin
                    if (pmem_resp) begin
                        pmem_read <= 1'b0;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Valid bits: flush clears all sets, but a fill landing on the same edge still installs valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
        end else begin
            if (flush) begin
                for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
            end
            if (state == FILL) begin
                valid_q[fill_idx][victim_q] <= 1'b1;
            end
        end
    end

    // Line capture and data/tag install; these arrays carry no reset since valid gates them.
    always_ff @(posedge clk) begin
        if ((state == FETCH) && pmem_resp) begin
            fill_buf <= pmem_rdata;
        end
        if ((state == FILL) && !rst) begin
            data_q[fill_idx][victim_q] <= fill_buf;
            tag_q[fill_idx][victim_q]  <= fill_tag;
        end
    end

endmodule

// File: tb/tb_l1_icache_assoc.sv
// Scoreboard bench for l1_icache_assoc with a fixed-latency line memory.
// Latency: memory answers on the 3rd cycle pmem_read is high.
// Backpressure: CPU side holds mem_read until mem_resp, bounded by a cycle budget.
module tb_l1_icache_assoc;

    localparam int LAT = 3;

    logic         clk;
    logic         rst;
    logic         mem_read;
    logic [15:0]  mem_address;
    logic         mem_resp;
    logic [15:0]  mem_rdata;
    logic         flush;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    typedef struct {
        logic [15:0] data;
        int          cyc;
        string       nm;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] fill_log[$];
    int          cyc;
    int          resp_count;
    int          total;
    int          passed;
    int          lat_cnt;

    l1_icache_assoc #(
        .NUM_WAYS   (2),
        .NUM_SETS   (8),
        .LINE_BYTES (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_resp     (mem_resp),
        .mem_rdata    (mem_rdata),
        .flush        (flush),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
        else passed++;
    endtask

    // Memory contents: each word holds its own byte address xor C3C3.
    function automatic logic [127:0] make_line(input logic [15:0] a);
        logic [127:0] l;
        for (int w = 0; w < 8; w++) l[w*16 +: 16] = ({a[15:4], 4'h0} + 16'(2 * w)) ^ 16'hC3C3;
        return l;
    endfunction

    // Line memory: responds after LAT cycles of a held pmem_read, forgets a dropped read.
    always @(negedge clk) begin
        if (pmem_read === 1'b1) begin
            lat_cnt++;
            if (lat_cnt == LAT) begin
                pmem_resp  = 1'b1;
                pmem_rdata = make_line(pmem_address);
                fill_log.push_back(pmem_address);
                lat_cnt    = 0;
            end else begin
                pmem_resp = 1'b0;
            end
        end else begin
            lat_cnt   = 0;
            pmem_resp = 1'b0;
        end
    end

    // Monitor: every mem_resp must match the oldest expected response in data and cycle.
    always @(negedge clk) begin
        if (rst === 1'b0 && mem_resp === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 32'(mem_address), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.nm, "_data"}, 32'(mem_rdata), 32'(e.data));
                check({e.nm, "_cycle"}, 32'(cyc), 32'(e.cyc));
            end
            resp_count++;
        end
    end

    // Issue one read at the current cycle and hold it until the monitor sees a response.
    task automatic do_read(input logic [15:0] a, input logic [15:0] d, input int lat,
                           input string nm, input bit with_flush);
        int start;
        int n;
        mem_address = a;
        mem_read    = 1'b1;
        flush       = with_flush;
        exp_q.push_back('{d, cyc + lat, nm});
        start = resp_count;
        n     = 0;
        do begin
            @(posedge clk);
            #1;
            flush = 1'b0;
            n++;
        end while (resp_count == start && n < 50);
        if (resp_count == start) begin
            check({nm, "_timeout"}, 32'(n), 32'(0));
            void'(exp_q.pop_back());
        end
        mem_read = 1'b0;
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        int nf;
        total       = 0;
        passed      = 0;
        resp_count  = 0;
        lat_cnt     = 0;
        rst         = 1'b1;
        mem_read    = 1'b0;
        mem_address = 16'h0000;
        flush       = 1'b0;
        pmem_resp   = 1'b0;
        pmem_rdata  = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_resp", 32'(mem_resp), 32'd0);
        check("rst_pmem_read", 32'(pmem_read), 32'd0);
        check("rst_pmem_address", 32'(pmem_address), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Cold miss, then a same-line hit on the last word.
        do_read(16'h1234, 16'hD1F7, 5, "cold_miss_1234", 1'b0);
        check("fill_count_cold", 32'(fill_log.size()), 32'd1);
        check("fill_addr_cold", 32'(fill_log[0]), 32'h1230);
        do_read(16'h123E, 16'hD1FD, 0, "hit_123E", 1'b0);
        check("fill_count_hit", 32'(fill_log.size()), 32'd1);

        // Set 0 replacement: 0x0000 is refreshed so 0x0100 evicts 0x0080.
        do_read(16'h0000, 16'hC3C3, 5, "miss_0000", 1'b0);
        do_read(16'h0080, 16'hC343, 5, "miss_0080", 1'b0);
        do_read(16'h0000, 16'hC3C3, 0, "hit_0000", 1'b0);
        do_read(16'h0100, 16'hC2C3, 5, "miss_0100", 1'b0);
        do_read(16'h0000, 16'hC3C3, 0, "still_hit_0000", 1'b0);
        nf = fill_log.size();
        do_read(16'h0080, 16'hC343, 5, "evicted_0080", 1'b0);
        check("fill_count_evict", 32'(fill_log.size()), 32'(nf + 1));
        check("fill_addr_evict", 32'(fill_log[fill_log.size()-1]), 32'h0080);

        // Hit coincident with flush still responds; the line is gone afterwards.
        do_read(16'h1230, 16'hD1F3, 0, "hit_with_flush", 1'b1);
        do_read(16'h1230, 16'hD1F3, 5, "reread_after_flush", 1'b0);

        // Reset in the middle of a fetch abandons the fill.
        flush_pulse();
        nf          = fill_log.size();
        mem_address = 16'h1230;
        mem_read    = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("pmem_read_after_rst", 32'(pmem_read), 32'd0);
        check("no_fill_after_rst", 32'(fill_log.size()), 32'(nf));
        @(posedge clk);
        #1;
        do_read(16'h1230, 16'hD1F3, 5, "miss_after_rst", 1'b0);

        // Dropped request: the 0x2000 fill completes silently, then 0x3000 is fetched.
        nf          = fill_log.size();
        mem_address = 16'h2000;
        mem_read    = 1'b1;
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        do_read(16'h3000, 16'hF3C3, 5, "miss_3000", 1'b0);
        check("fill_count_drop", 32'(fill_log.size()), 32'(nf + 2));
        check("fill_addr_dropped", 32'(fill_log[nf]), 32'h2000);
        check("fill_addr_3000", 32'(fill_log[nf+1]), 32'h3000);
        do_read(16'h2000, 16'hE3C3, 0, "hit_2000", 1'b0);

        repeat (5) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
